// File: rtl/izh_pkg.sv
// Shared definitions for the Izhikevich datapath: FSM state encoding and
// signed fixed-point width / saturation-limit helpers.
package izh_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        RD   = 4'b0010,
        ADD  = 4'b0100,
        WR   = 4'b1000
    } state_t;

    // Data words carry NUMWIDTH as the MSB index, so the width is one more.
    function automatic int data_w(input int numwidth);
        return numwidth + 1;
    endfunction

    function automatic longint sat_max(input int numwidth);
        return (longint'(1) << numwidth) - 1;
    endfunction

    function automatic longint sat_min(input int numwidth);
        return longint'(1) << numwidth;
    endfunction

endpackage

// File: rtl/inext_accum_arbiter_if.sv
// Bundle between the SPU array, the i_next memory and the accumulate arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface inext_accum_arbiter_if
    import izh_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int NUMWIDTH = 16,
    parameter int TAGBITS  = 1
);
    localparam int DW = data_w(NUMWIDTH);

    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*TAGBITS-1:0] req_tag;
    logic [NUM_REQ*DW-1:0]      req_weight;
    logic [NUM_REQ-1:0]         ack;
    logic                       hold;
    logic                       mem_rd_en;
    logic [TAGBITS-1:0]         mem_rd_addr;
    logic [DW-1:0]              mem_rd_data;
    logic                       mem_wr_en;
    logic [TAGBITS-1:0]         mem_wr_addr;
    logic [DW-1:0]              mem_wr_data;
    logic                       busy;
    logic                       sat_flag;
    logic                       sat_clr;

    modport slave (
        input  req, req_tag, req_weight, hold, mem_rd_data, sat_clr,
        output ack, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr,
               mem_wr_data, busy, sat_flag
    );

    modport master (
        output req, req_tag, req_weight, hold, mem_rd_data, sat_clr,
        input  ack, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr,
               mem_wr_data, busy, sat_flag
    );

endinterface

// File: rtl/fixed_sat_adder.sv
// Signed two's-complement adder that clamps to the representable range
// instead of wrapping; sat reports that clamping happened.
module fixed_sat_adder
    import izh_pkg::*;
#(
    parameter int NUMWIDTH = 16
) (
    input  logic [NUMWIDTH:0] a,
    input  logic [NUMWIDTH:0] b,
    output logic [NUMWIDTH:0] sum,
    output logic              sat
);
    localparam int            DW   = data_w(NUMWIDTH);
    localparam logic [DW-1:0] MAXV = DW'(sat_max(NUMWIDTH));
    localparam logic [DW-1:0] MINV = DW'(sat_min(NUMWIDTH));

    logic [DW:0] wide_sum;

    assign wide_sum = {a[DW-1], a} + {b[DW-1], b};

    // The two top bits of the widened sum disagree exactly on overflow;
    // the extra sign bit tells which direction it went.
    always_comb begin
        sat = 1'b0;
        sum = wide_sum[DW-1:0];
        if (wide_sum[DW] != wide_sum[DW-1]) begin
            sat = 1'b1;
            sum = wide_sum[DW] ? MINV : MAXV;
        end
    end

endmodule

// File: rtl/inext_accum_arbiter.sv
// Round-robin arbiter that owns the i_next port and performs each SPU's
// read-add-write atomically, so same-tag updates can never interleave.
module inext_accum_arbiter
    import izh_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int NUMWIDTH = 16,
    parameter int TAGBITS  = 1
) (
    input  logic                  clk,
    input  logic                  asyn_reset,
    inext_accum_arbiter_if.slave  bus
);
    localparam int                DW    = data_w(NUMWIDTH);
    localparam int                IDXW  = $clog2(NUM_REQ);
    localparam logic [IDXW:0]     NR_W  = (IDXW+1)'(NUM_REQ);
    localparam logic [IDXW-1:0]   LAST  = IDXW'(NUM_REQ - 1);

    logic [TAGBITS-1:0] tag_arr [NUM_REQ];
    logic [DW-1:0]      wt_arr  [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign tag_arr[gi] = bus.req_tag[gi*TAGBITS +: TAGBITS];
            assign wt_arr[gi]  = bus.req_weight[gi*DW +: DW];
        end
    endgenerate

    state_t             state_reg, state_next;
    logic [IDXW-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [IDXW-1:0]    grant_idx_reg, grant_idx_next;
    logic [TAGBITS-1:0] tag_reg, tag_next;
    logic [DW-1:0]      wt_reg, wt_next;
    logic [DW-1:0]      result_reg, result_next;
    logic               sat_reg, sat_next;
    logic               sat_flag_reg, sat_flag_next;

    logic               win_found;
    logic [IDXW-1:0]    win_idx;
    logic [IDXW:0]      rr_sum;
    logic [IDXW-1:0]    rr_idx;

    logic [DW-1:0]      add_sum;
    logic               add_sat;

    logic [NUM_REQ-1:0] ack_v;
    logic               rd_en_v, wr_en_v;
    logic [TAGBITS-1:0] rd_addr_v, wr_addr_v;
    logic [DW-1:0]      wr_data_v;

    fixed_sat_adder #(.NUMWIDTH(NUMWIDTH)) u_add (
        .a   (bus.mem_rd_data),
        .b   (wt_reg),
        .sum (add_sum),
        .sat (add_sat)
    );

    // Scan from rr_ptr upward; the wrap is an explicit subtract so that
    // non-power-of-two requester counts rotate correctly.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_sum    = '0;
        rr_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_sum = {1'b0, rr_ptr_reg} + (IDXW+1)'(k);
            if (rr_sum >= NR_W)
                rr_sum = rr_sum - NR_W;
            rr_idx = rr_sum[IDXW-1:0];
            if (!win_found && bus.req[rr_idx]) begin
                win_found = 1'b1;
                win_idx   = rr_idx;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_idx_next = grant_idx_reg;
        tag_next       = tag_reg;
        wt_next        = wt_reg;
        result_next    = result_reg;
        sat_next       = sat_reg;
        sat_flag_next  = sat_flag_reg;
        ack_v          = '0;
        rd_en_v        = 1'b0;
        rd_addr_v      = '0;
        wr_en_v        = 1'b0;
        wr_addr_v      = '0;
        wr_data_v      = '0;
        case (state_reg)
            IDLE: begin
                if (!bus.hold && win_found) begin
                    grant_idx_next = win_idx;
                    tag_next       = tag_arr[win_idx];
                    wt_next        = wt_arr[win_idx];
                    state_next     = RD;
                end
            end
            RD: begin
                rd_en_v    = 1'b1;
                rd_addr_v  = tag_reg;
                state_next = ADD;
            end
            ADD: begin
                result_next = add_sum;
                sat_next    = add_sat;
                state_next  = WR;
            end
            WR: begin
                wr_en_v     = 1'b1;
                wr_addr_v   = tag_reg;
                wr_data_v   = result_reg;
                ack_v       = NUM_REQ'(1) << grant_idx_reg;
                if (sat_reg)
                    sat_flag_next = 1'b1;
                rr_ptr_next = (grant_idx_reg == LAST) ? '0 : grant_idx_reg + IDXW'(1);
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A clear in the same cycle as a new saturation still leaves the flag low.
        if (bus.sat_clr)
            sat_flag_next = 1'b0;
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            grant_idx_reg <= '0;
            tag_reg       <= '0;
            wt_reg        <= '0;
            result_reg    <= '0;
            sat_reg       <= 1'b0;
            sat_flag_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            grant_idx_reg <= grant_idx_next;
            tag_reg       <= tag_next;
            wt_reg        <= wt_next;
            result_reg    <= result_next;
            sat_reg       <= sat_next;
            sat_flag_reg  <= sat_flag_next;
        end
    end

    assign bus.ack         = ack_v;
    assign bus.mem_rd_en   = rd_en_v;
    assign bus.mem_rd_addr = rd_addr_v;
    assign bus.mem_wr_en   = wr_en_v;
    assign bus.mem_wr_addr = wr_addr_v;
    assign bus.mem_wr_data = wr_data_v;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.sat_flag    = sat_flag_reg;

endmodule

// File: tb/tb_inext_accum_arbiter.sv
// Directed and randomized check of the accumulate arbiter against a
// transaction-level model with its own copy of i_next.
module tb_inext_accum_arbiter;
    localparam int NR = 2, NW = 16, TB = 1, DW = NW + 1, DEPTH = 1 << TB;
    localparam int MAXV = (1 << NW) - 1;
    localparam int MINV = -(1 << NW);

    logic clk = 1'b0;
    logic asyn_reset;
    always #5 clk = ~clk;

    inext_accum_arbiter_if #(.NUM_REQ(NR), .NUMWIDTH(NW), .TAGBITS(TB)) bus ();

    inext_accum_arbiter #(.NUM_REQ(NR), .NUMWIDTH(NW), .TAGBITS(TB)) dut (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .bus        (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Environment memory: registered read, write on strobe.
    logic [DW-1:0] mem [DEPTH];
    initial forever begin
        @(posedge clk);
        if (bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
    end

    // Reference model: op phase (0 idle, 1 read, 2 add, 3 write), last winner,
    // round-robin start, private memory copy and sticky saturation flag.
    int            ph, win, rr;
    logic [TB-1:0] mtag;
    logic [DW-1:0] mwt, mres;
    bit            msat, mflag;
    logic [DW-1:0] refmem [DEPTH];

    function automatic logic [DW-1:0] ref_sat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              output bit s);
        logic signed [DW-1:0] sa, sb;
        int sum;
        sa = a;
        sb = b;
        sum = int'(sa) + int'(sb);
        s = 1'b0;
        if (sum > MAXV) begin s = 1'b1; return DW'(MAXV); end
        if (sum < MINV) begin s = 1'b1; return DW'(MINV); end
        return DW'(sum);
    endfunction

    task model_reset();
        ph = 0; win = 0; rr = 0; mtag = '0; mwt = '0; mres = '0; msat = 0; mflag = 0;
    endtask

    initial forever begin
        @(posedge asyn_reset);
        model_reset();
    end

    // Transaction logs for the directed literal checks.
    int wr_addr_q[$];
    int wr_data_q[$];
    int ack_q[$];
    int rd_cnt, busy_cnt;

    task clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); ack_q.delete();
        rd_cnt = 0; busy_cnt = 0;
    endtask

    initial begin
        model_reset();
        clear_logs();
        forever begin
            @(posedge clk);
            if (asyn_reset) model_reset();
            else begin
                case (ph)
                    0: if (!bus.hold && bus.req != 0) begin
                        for (int k = 0; k < NR; k++) begin
                            int i;
                            i = (rr + k) % NR;
                            if (ph == 0 && bus.req[i]) begin
                                win  = i;
                                mtag = bus.req_tag[i*TB +: TB];
                                mwt  = bus.req_weight[i*DW +: DW];
                                ph   = 1;
                            end
                        end
                    end
                    1: ph = 2;
                    2: begin mres = ref_sat(refmem[mtag], mwt, msat); ph = 3; end
                    default: begin
                        refmem[mtag] = mres;
                        if (msat) mflag = 1;
                        rr = (win + 1) % NR;
                        ph = 0;
                    end
                endcase
                if (bus.sat_clr) mflag = 0;
            end
            #1;
            check("busy",    bus.busy,        ph != 0);
            check("rd_en",   bus.mem_rd_en,   ph == 1);
            check("rd_addr", bus.mem_rd_addr, (ph == 1) ? mtag : '0);
            check("wr_en",   bus.mem_wr_en,   ph == 3);
            check("wr_addr", bus.mem_wr_addr, (ph == 3) ? mtag : '0);
            check("wr_data", bus.mem_wr_data, (ph == 3) ? mres : '0);
            check("ack",     bus.ack,         (ph == 3) ? (NR'(1) << win) : '0);
            check("sat_flag", bus.sat_flag,   mflag);
            if (bus.busy) busy_cnt++;
            if (bus.mem_rd_en) rd_cnt++;
            if (bus.mem_wr_en) begin
                wr_addr_q.push_back(int'(bus.mem_wr_addr));
                wr_data_q.push_back(int'(bus.mem_wr_data));
            end
            for (int i = 0; i < NR; i++)
                if (bus.ack[i]) begin
                    ack_q.push_back(i);
                    $display("txn: req=%0d tag=%0d weight=%05h wdata=%05h sat_flag=%0d",
                             i, bus.mem_wr_addr, mwt, bus.mem_wr_data, mflag);
                end
        end
    end

    // Requester driver: each SPU works through its own queue of ops, holding
    // req/tag/weight until ack and presenting the next op on the ack edge.
    typedef struct packed {
        logic [TB-1:0] tag;
        logic [DW-1:0] wt;
    } op_t;
    op_t opq [NR][$];
    op_t drv_op;
    bit  rand_en = 0;

    initial begin
        bus.req = '0; bus.req_tag = '0; bus.req_weight = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (rand_en && opq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    drv_op.tag = TB'($urandom_range(0, DEPTH - 1));
                    drv_op.wt  = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 63) - 32)
                                                             : DW'($urandom);
                    opq[i].push_back(drv_op);
                end
                if (bus.ack[i] || !bus.req[i]) begin
                    if (opq[i].size() > 0) begin
                        drv_op = opq[i].pop_front();
                        bus.req[i] = 1'b1;
                        bus.req_tag[i*TB +: TB]    = drv_op.tag;
                        bus.req_weight[i*DW +: DW] = drv_op.wt;
                    end else begin
                        bus.req[i] = 1'b0;
                    end
                end
            end
        end
    end

    task preload(input int addr, input logic [DW-1:0] val);
        mem[addr]    = val;
        refmem[addr] = val;
    endtask

    task push(input int i, input int tag, input logic [DW-1:0] wt);
        drv_op.tag = TB'(tag);
        drv_op.wt  = wt;
        opq[i].push_back(drv_op);
    endtask

    task drain(input int maxc);
        int c;
        c = 0;
        do begin
            @(negedge clk); #2;
            c++;
        end while ((opq[0].size() != 0 || opq[1].size() != 0 || bus.req != 0 || bus.busy) && c < maxc);
        check("drain_within_budget", c < maxc, 1);
    endtask

    task wait_rd(input int maxc);
        int c;
        c = 0;
        while (!bus.mem_rd_en && c < maxc) begin
            @(negedge clk);
            c++;
        end
        check("rd_within_budget", c < maxc, 1);
    endtask

    task do_reset();
        @(negedge clk);
        asyn_reset = 1'b1;
        @(negedge clk);
        asyn_reset = 1'b0;
    endtask

    initial begin
        asyn_reset = 1'b1;
        bus.hold = 1'b0; bus.sat_clr = 1'b0; bus.mem_rd_data = '0;
        for (int a = 0; a < DEPTH; a++) preload(a, '0);
        repeat (3) @(negedge clk);
        asyn_reset = 1'b0;
        #1;
        check("reset_busy",     bus.busy, 0);
        check("reset_ack",      bus.ack, 0);
        check("reset_rd_en",    bus.mem_rd_en, 0);
        check("reset_wr_en",    bus.mem_wr_en, 0);
        check("reset_wr_data",  bus.mem_wr_data, 0);
        check("reset_sat_flag", bus.sat_flag, 0);

        // Single accumulate: 5 + 0x10 into tag 1.
        preload(1, 17'h00005);
        clear_logs();
        push(0, 1, 17'h00010);
        drain(40);
        check("single_wr_cnt",  wr_data_q.size(), 1);
        check("single_wr_addr", wr_addr_q[0], 1);
        check("single_wr_data", wr_data_q[0], 17'h00015);
        check("single_ack_idx", ack_q[0], 0);
        check("single_busy_cycles", busy_cnt, 3);
        check("single_rd_cnt",  rd_cnt, 1);

        // Contention from reset: grants must alternate 0,1,0,1.
        do_reset();
        clear_logs();
        push(0, 0, 17'h1); push(0, 0, 17'h1);
        push(1, 1, 17'h2); push(1, 1, 17'h2);
        drain(60);
        check("rr_ack_count", ack_q.size(), 4);
        for (int k = 0; k < 4 && k < ack_q.size(); k++)
            check("rr_order", ack_q[k], k % 2);

        // Same-tag race: second read must see the first write.
        do_reset();
        preload(0, '0);
        clear_logs();
        push(0, 0, 17'd3);
        push(1, 0, 17'd4);
        drain(40);
        check("race_first_wr",  wr_data_q[0], 3);
        check("race_second_wr", wr_data_q[1], 7);
        check("race_mem0",      mem[0], 7);

        // Saturation in both directions, then sticky-flag clear.
        preload(0, 17'h0FFF0);
        clear_logs();
        push(0, 0, 17'h00020);
        drain(40);
        check("sat_pos_wr", wr_data_q[0], 17'h0FFFF);
        check("sat_flag_set", bus.sat_flag, 1);
        preload(1, 17'h10010);
        clear_logs();
        push(1, 1, 17'h1FFE0);
        drain(40);
        check("sat_neg_wr", wr_data_q[0], 17'h10000);
        check("sat_flag_sticky", bus.sat_flag, 1);
        bus.sat_clr = 1'b1;
        @(negedge clk);
        bus.sat_clr = 1'b0;
        check("sat_flag_cleared", bus.sat_flag, 0);

        // Hold with a pending request: no grant for 10 cycles.
        clear_logs();
        bus.hold = 1'b1;
        push(0, 0, 17'h1);
        repeat (10) @(negedge clk);
        check("hold_no_rd", rd_cnt, 0);
        check("hold_not_busy", bus.busy, 0);
        push(1, 1, 17'h1);
        bus.hold = 1'b0;
        wait_rd(20);
        @(negedge clk);
        bus.hold = 1'b1;
        repeat (10) @(negedge clk);
        check("hold_mid_op_acks", ack_q.size(), 1);
        check("hold_mid_op_busy", bus.busy, 0);
        bus.hold = 1'b0;
        drain(40);
        check("hold_release_acks", ack_q.size(), 2);

        // Asynchronous reset while in ADD aborts the op without a write.
        preload(1, 17'h00100);
        clear_logs();
        push(0, 1, 17'h00007);
        wait_rd(20);
        @(negedge clk);
        #2 asyn_reset = 1'b1;
        #1;
        check("arst_busy",  bus.busy, 0);
        check("arst_wr_en", bus.mem_wr_en, 0);
        check("arst_ack",   bus.ack, 0);
        #1 asyn_reset = 1'b0;
        drain(40);
        check("arst_wr_cnt",  wr_data_q.size(), 1);
        check("arst_wr_data", wr_data_q[0], 17'h00107);
        check("arst_mem1",    mem[1], 17'h00107);

        // Randomized traffic with hold, sat_clr and rare reset pulses.
        rand_en = 1;
        repeat (3000) begin
            @(negedge clk);
            bus.hold    = ($urandom_range(0, 7) == 0);
            bus.sat_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 asyn_reset = 1'b1;
                #2 asyn_reset = 1'b0;
            end
        end
        rand_en = 0;
        @(negedge clk);
        bus.hold = 1'b0;
        bus.sat_clr = 1'b0;
        drain(200);
        for (int a = 0; a < DEPTH; a++)
            check("final_mem", mem[a], refmem[a]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
